// File: rtl/dma_rd_responder_pkg.sv
// Shared types and defaults for the DMA read responder: widths, FSM states,
// latched configuration and window-walk position.
package dma_rd_responder_pkg;

    localparam int DMA_DATA_W   = 16;
    localparam int DMA_ADDR_W   = 24;
    localparam int DMA_PF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0]  kernel;
        logic [7:0]  i_side;
        logic [7:0]  o_side;
        logic [3:0]  stride;
        logic [3:0]  pad;
        logic [15:0] i_channel;
    } cfg_t;

    typedef struct packed {
        logic [7:0]  oy;
        logic [7:0]  ox;
        logic [7:0]  ky;
        logic [7:0]  kx;
        logic [15:0] ch;
    } pos_t;

    // A zero limit behaves like one so a bad config can never stall a counter.
    function automatic logic at_last(input logic [15:0] cnt, input logic [15:0] lim);
        return ({1'b0, cnt} + 17'd1) >= {1'b0, lim};
    endfunction

endpackage

// File: rtl/dma_rd_fifo.sv
// Prefetch FIFO between memory returns and the engine; push and pop in the
// same cycle are accepted even when full.
module dma_rd_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_rd_responder.sv
// Convolution-window read responder: walks ch/kx/ky/ox/oy, prefetches words
// into a small FIFO and hands one word per engine request. Define
// DMA_RD_ZERO_PAD_EN to synthesize zero words for out-of-image positions.
module dma_rd_responder
    import dma_rd_responder_pkg::*;
#(
    parameter int DATA_W   = DMA_DATA_W,
    parameter int ADDR_W   = DMA_ADDR_W,
    parameter int PF_DEPTH = DMA_PF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [7:0]        cfg_kernel,
    input  logic [7:0]        cfg_i_side,
    input  logic [7:0]        cfg_o_side,
    input  logic [3:0]        cfg_stride,
    input  logic [3:0]        cfg_pad,
    input  logic [15:0]       cfg_i_channel,
    input  logic              dma_reads_en,
    output logic [DATA_W-1:0] dma_ob_data,
    output logic              dma_ob_we,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              busy,
    output logic              done,
    output logic              underflow
);

    localparam int CW = $clog2(PF_DEPTH) + 1;

    state_e            state, state_nxt;
    cfg_t              cfg_r;
    cfg_t              cfg_in;
    logic [ADDR_W-1:0] base_r;
    pos_t              pos, pos_nxt;
    logic              l_ch, l_kx, l_ky, l_ox, l_oy, last_pos;
    logic              accept, room, issue, issue_rd, pad_pos;
    logic              pend_vld, pend_pad;
    logic signed [15:0] xs, ys;
    logic [ADDR_W-1:0] x_a, y_a, rd_addr;
    logic [3:0]        cfg_pad_eff;
    logic              fifo_push, fifo_pop, fifo_empty, unused_full;
    logic [DATA_W-1:0] fifo_head, push_data;
    logic [CW-1:0]     fifo_cnt;

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && cfg_valid;

    assign cfg_in = '{kernel: cfg_kernel, i_side: cfg_i_side, o_side: cfg_o_side,
                      stride: cfg_stride, pad: cfg_pad_eff, i_channel: cfg_i_channel};

    // Image coordinates may go negative with padding; keep them signed.
    assign xs = 16'(pos.ox) * 16'(cfg_r.stride) + 16'(pos.kx) - 16'(cfg_r.pad);
    assign ys = 16'(pos.oy) * 16'(cfg_r.stride) + 16'(pos.ky) - 16'(cfg_r.pad);
    assign x_a = ADDR_W'(xs);
    assign y_a = ADDR_W'(ys);
    assign rd_addr = base_r + (y_a * ADDR_W'(cfg_r.i_side) + x_a) * ADDR_W'(cfg_r.i_channel)
                   + ADDR_W'(pos.ch);

`ifdef DMA_RD_ZERO_PAD_EN
    assign cfg_pad_eff = cfg_pad;
    assign pad_pos = xs[15] || ys[15] ||
                     (xs[14:0] >= 15'(cfg_r.i_side)) || (ys[14:0] >= 15'(cfg_r.i_side));
`else
    logic unused_pad;
    assign unused_pad  = ^cfg_pad;
    assign cfg_pad_eff = '0;
    assign pad_pos     = 1'b0;
`endif

    // Count in-flight reads against the FIFO so a return always has a slot.
    assign room     = (int'(fifo_cnt) + int'(pend_vld)) < PF_DEPTH;
    assign issue    = (state == RUN) && room;
    assign issue_rd = issue && !pad_pos;

    assign mem_rd_en = issue_rd;
    assign mem_addr  = issue_rd ? rd_addr : '0;

    assign fifo_push = pend_vld && (pend_pad || mem_rd_valid);
    assign push_data = pend_pad ? '0 : mem_rd_data;
    assign fifo_pop  = busy && dma_reads_en && !fifo_empty;

    always_comb begin
        l_ch = at_last(pos.ch, cfg_r.i_channel);
        l_kx = at_last(16'(pos.kx), 16'(cfg_r.kernel));
        l_ky = at_last(16'(pos.ky), 16'(cfg_r.kernel));
        l_ox = at_last(16'(pos.ox), 16'(cfg_r.o_side));
        l_oy = at_last(16'(pos.oy), 16'(cfg_r.o_side));
        last_pos = l_ch && l_kx && l_ky && l_ox && l_oy;
        pos_nxt = pos;
        pos_nxt.ch = l_ch ? '0 : pos.ch + 16'd1;
        if (l_ch)                         pos_nxt.kx = l_kx ? '0 : pos.kx + 8'd1;
        if (l_ch && l_kx)                 pos_nxt.ky = l_ky ? '0 : pos.ky + 8'd1;
        if (l_ch && l_kx && l_ky)         pos_nxt.ox = l_ox ? '0 : pos.ox + 8'd1;
        if (l_ch && l_kx && l_ky && l_ox) pos_nxt.oy = l_oy ? '0 : pos.oy + 8'd1;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (cfg_valid) state_nxt = RUN;
            RUN:     if (issue && last_pos) state_nxt = DRAIN;
            DRAIN: begin
                if (fifo_empty && !pend_vld) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cfg_r       <= '0;
            base_r      <= '0;
            pos         <= '0;
            pend_vld    <= 1'b0;
            pend_pad    <= 1'b0;
            dma_ob_we   <= 1'b0;
            dma_ob_data <= '0;
            underflow   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_vld  <= issue;
            pend_pad  <= issue && pad_pos;
            dma_ob_we <= fifo_pop;
            if (fifo_pop) dma_ob_data <= fifo_head;
            // Once every word has gone out, a request is past the transfer, not starved.
            if (busy && !done && dma_reads_en && fifo_empty) underflow <= 1'b1;
            if (accept) begin
                cfg_r  <= cfg_in;
                base_r <= cfg_base;
                pos    <= '0;
            end else if (issue) begin
                pos <= pos_nxt;
            end
        end
    end

    dma_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (PF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_cnt),
        .empty     (fifo_empty),
        .full      (unused_full)
    );

endmodule

// File: tb/tb_dma_rd_responder.sv
// Scoreboard bench for dma_rd_responder: a loop-nest model of the window walk
// feeds expected address/data queues that a negedge monitor drains.
module tb_dma_rd_responder;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 24;
    localparam int PF_DEPTH = 4;
`ifdef DMA_RD_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [7:0]        cfg_kernel = '0, cfg_i_side = '0, cfg_o_side = '0;
    logic [3:0]        cfg_stride = '0, cfg_pad = '0;
    logic [15:0]       cfg_i_channel = '0;
    logic              dma_reads_en = 1'b0;
    logic [DATA_W-1:0] dma_ob_data;
    logic              dma_ob_we;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              mem_rd_valid = 1'b0;
    logic              busy, done, underflow;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int rd_cnt = 0;
    logic req_d = 1'b0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    dma_rd_responder #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PF_DEPTH (PF_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_base      (cfg_base),
        .cfg_kernel    (cfg_kernel),
        .cfg_i_side    (cfg_i_side),
        .cfg_o_side    (cfg_o_side),
        .cfg_stride    (cfg_stride),
        .cfg_pad       (cfg_pad),
        .cfg_i_channel (cfg_i_channel),
        .dma_reads_en  (dma_reads_en),
        .dma_ob_data   (dma_ob_data),
        .dma_ob_we     (dma_ob_we),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_valid  (mem_rd_valid),
        .busy          (busy),
        .done          (done),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] memfn(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] h;
        h = a * 24'd40503 + (a >> 9);
        return DATA_W'(h) ^ 16'h5A3C;
    endfunction

    // One-cycle memory; non-returning cycles carry junk data.
    always @(posedge clk) begin
        mem_rd_valid <= mem_rd_en;
        mem_rd_data  <= mem_rd_en ? memfn(mem_addr) : DATA_W'($urandom);
        req_d        <= dma_reads_en;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (mem_rd_en) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_addr_extra: actual=%0h required=none", mem_addr);
                end else chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (dma_ob_we) begin
                we_cnt++;
                chk("we_after_req", 32'(req_d), 32'd1);
                if (exp_data_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ob_data_extra: actual=%0h required=none", dma_ob_data);
                end else chk("ob_data", 32'(dma_ob_data), 32'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        dma_reads_en = 1'b0;
        @(posedge clk);
        #1;
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ob_we", 32'(dma_ob_we), 32'd0);
        chk("rst_ob_data", 32'(dma_ob_data), 32'd0);
        rst = 1'b0;
    endtask

    // Issue a config pulse and queue the expected read/word streams.
    task automatic start(input logic [ADDR_W-1:0] base, input int k, input int is,
                         input int os, input int st, input int pd, input int ic);
        int p, x, y;
        logic [ADDR_W-1:0] a;
        cfg_base = base; cfg_kernel = 8'(k); cfg_i_side = 8'(is); cfg_o_side = 8'(os);
        cfg_stride = 4'(st); cfg_pad = 4'(pd); cfg_i_channel = 16'(ic);
        cfg_valid = 1'b1;
        p = PAD_EN ? pd : 0;
        for (int oy = 0; oy < os; oy++)
            for (int ox = 0; ox < os; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++)
                        for (int ch = 0; ch < ic; ch++) begin
                            x = ox * st + kx - p;
                            y = oy * st + ky - p;
                            if (PAD_EN && (x < 0 || y < 0 || x >= is || y >= is)) begin
                                exp_data_q.push_back('0);
                            end else begin
                                a = base + ADDR_W'((y * is + x) * ic + ch);
                                exp_addr_q.push_back(a);
                                exp_data_q.push_back(memfn(a));
                            end
                        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // mode 0: random requests; mode 1: prefill then hold requests high.
    task automatic run(input int mode, input bit poke);
        int d0, cyc, got, gaps, n;
        d0 = done_cnt; cyc = 0; got = 0; gaps = 0;
        n = exp_data_q.size();
        if (mode == 1) begin
            repeat (10) @(negedge clk);
            dma_reads_en = 1'b1;
        end
        while (done_cnt == d0 && cyc < 4000) begin
            if (mode == 0) dma_reads_en = ($urandom_range(0, 9) < 6);
            if (poke && cyc == 15) begin
                cfg_valid = 1'b1;
                cfg_base = ADDR_W'($urandom);
                cfg_kernel = 8'd1; cfg_o_side = 8'd1; cfg_i_channel = 16'd1;
            end else cfg_valid = 1'b0;
            @(negedge clk);
            cyc++;
            if (mode == 1 && got < n) begin
                if (dma_ob_we) got++;
                else gaps++;
                if (got == n) dma_reads_en = 1'b0;
            end
        end
        dma_reads_en = 1'b0;
        cfg_valid = 1'b0;
        if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL done_timeout: actual=no done after %0d cycles required=done", cyc);
        end
        repeat (3) @(negedge clk);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("words_left", 32'(exp_data_q.size()), 32'd0);
        chk("reads_left", 32'(exp_addr_q.size()), 32'd0);
        if (mode == 1) begin
            chk("stream_gaps", 32'(gaps), 32'd0);
            chk("stream_underflow", 32'(underflow), 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, cyc, k, st, os, ic, is, pd;
        logic [ADDR_W-1:0] b;
        repeat (2) @(negedge clk);
        do_reset();

        // Reference transfer streamed back-to-back after prefill.
        w0 = we_cnt;
        start(24'd0, 3, 7, 3, 2, 0, 3);
        run(1, 1'b0);
        chk("words_243", 32'(we_cnt - w0), 32'd243);

        // Request on an empty FIFO straight after start.
        do_reset();
        start(24'h100, 2, 5, 2, 2, 0, 2);
        dma_reads_en = 1'b1;
        @(negedge clk);
        chk("underflow_set", 32'(underflow), 32'd1);
        chk("underflow_no_we", 32'(dma_ob_we), 32'd0);
        run(0, 1'b0);
        chk("underflow_sticky", 32'(underflow), 32'd1);

        // A second cfg_valid mid-transfer must not disturb the stream.
        start(24'h2000, 3, 7, 3, 2, 0, 3);
        run(0, 1'b1);

        repeat (6) begin
            k  = $urandom_range(1, 3);
            st = $urandom_range(1, 3);
            os = $urandom_range(1, 3);
            ic = $urandom_range(1, 4);
            is = (os - 1) * st + k + $urandom_range(0, 2);
            pd = $urandom_range(0, 2);
            b  = ADDR_W'($urandom_range(0, 24'hFFFFF));
            start(b, k, is, os, st, pd, ic);
            run(0, 1'b0);
        end

        // Border case: 49 of 81 positions fall inside a padded 3x3 image.
        r0 = rd_cnt;
        start(24'h40, 3, 3, 3, 1, 1, 1);
        run(0, 1'b0);
        chk("pad_read_count", 32'(rd_cnt - r0), PAD_EN ? 32'd49 : 32'd81);

        // Abort mid-transfer, then restart from a new base.
        do_reset();
        start(24'd0, 3, 7, 3, 2, 0, 3);
        w0 = we_cnt; cyc = 0;
        while ((we_cnt - w0) < 100 && cyc < 4000) begin
            dma_reads_en = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            cyc++;
        end
        chk("reached_word_100", 32'((we_cnt - w0) >= 100), 32'd1);
        do_reset();
        b = ADDR_W'($urandom_range(24'h1000, 24'hFFFFF));
        start(b, 2, 4, 2, 2, 0, 2);
        run(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
